// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, frame constants, parity helper.
// Used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } uart_state_t;

    localparam int   DATA_BITS  = 8;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for an asynchronous single-bit input.
// Reset value is a parameter so an idle-high line never looks active.
module uart_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ff <= {STAGES{RESET_VAL}};
        end else begin
            r_ff <= {r_ff[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_ff[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, 8 data bits LSB first, even parity, stop.
// Samples each bit at mid-bit and reports the byte with error flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int H  = (CLKS_PER_BIT - 1) / 2;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MID  = CW'(H);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    logic                 w_rx_s;
    uart_state_t          r_state;
    logic [CW-1:0]        r_clk_cnt;
    logic [2:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic [7:0]           r_data;
    logic                 r_valid;
    logic                 r_perr;
    logic                 r_ferr;

    uart_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (IDLE_LEVEL)
    ) u_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .i_d   (rx),
        .o_q   (w_rx_s)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    // This cycle is offset 0 of the start bit.
                    if (w_rx_s == START_BIT) begin
                        if (H == 0) begin
                            r_state   <= S_DATA;
                            r_clk_cnt <= '0;
                        end else begin
                            r_state   <= S_START;
                            r_clk_cnt <= CW'(1);
                        end
                    end
                end
                S_START: begin
                    if (r_clk_cnt == CNT_MID) begin
                        r_clk_cnt <= '0;
                        r_state   <= (w_rx_s == START_BIT) ? S_DATA : S_IDLE;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (r_clk_cnt == CNT_LAST) begin
                        r_shift[r_bit_idx] <= w_rx_s;
                        r_clk_cnt          <= '0;
                        r_bit_idx          <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'(DATA_BITS - 1)) begin
                            r_state <= S_PARITY;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end
                end
                S_PARITY: begin
                    if (r_clk_cnt == CNT_LAST) begin
                        r_par     <= w_rx_s;
                        r_clk_cnt <= '0;
                        r_state   <= S_STOP;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (r_clk_cnt == CNT_LAST) begin
                        r_data    <= r_shift;
                        r_perr    <= even_parity(r_shift) ^ r_par;
                        r_ferr    <= (w_rx_s != STOP_BIT);
                        r_valid   <= 1'b1;
                        r_clk_cnt <= '0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign parity_err = r_perr;
    assign frame_err  = r_ferr;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboarded bench for uart_rx at 1 and 16 clocks per bit.
// Frames are queued with their expected result; monitors check pulses.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rx1;
    logic       rx16;
    logic [7:0] dout1, dout16;
    logic       dv1, dv16;
    logic       pe1, pe16;
    logic       fe1, fe16;
    logic       busy1, busy16;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        int         t0;
    } exp_t;

    exp_t q1[$];
    exp_t q16[$];

    uart_rx #(.CLKS_PER_BIT(1), .SYNC_STAGES(2)) dut1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx         (rx1),
        .data_out   (dout1),
        .data_valid (dv1),
        .parity_err (pe1),
        .frame_err  (fe1),
        .busy       (busy1)
    );

    uart_rx #(.CLKS_PER_BIT(16), .SYNC_STAGES(2)) dut16 (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx         (rx16),
        .data_out   (dout16),
        .data_valid (dv16),
        .parity_err (pe16),
        .frame_err  (fe16),
        .busy       (busy16)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Edge T samples the start bit into the synchronizer; the start
    // sample is SYNC_STAGES later plus the mid-bit offset, and the stop
    // sample is ten bit periods after that.
    function automatic int latency(input int cpb);
        return 2 + (cpb - 1) / 2 + 10 * cpb;
    endfunction

    always @(negedge clk) begin
        if (reset_n && dv1) begin
            exp_t e;
            if (q1.size() == 0) begin
                check("dut1 unexpected pulse", 1, 0);
            end else begin
                e = q1.pop_front();
                check("dut1 data", dout1, e.d);
                check("dut1 parity_err", pe1, e.pe);
                check("dut1 frame_err", fe1, e.fe);
                check("dut1 latency", cyc - e.t0, latency(1));
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && dv16) begin
            exp_t e;
            if (q16.size() == 0) begin
                check("dut16 unexpected pulse", 1, 0);
            end else begin
                e = q16.pop_front();
                check("dut16 data", dout16, e.d);
                check("dut16 parity_err", pe16, e.pe);
                check("dut16 frame_err", fe16, e.fe);
                check("dut16 latency", cyc - e.t0, latency(16));
            end
        end
    end

    // Called at a negedge; the start bit is captured at the next posedge.
    task automatic send(input bit sel16, input logic [7:0] d,
                        input logic par, input logic stop);
        int          cpb;
        logic [10:0] bits;
        exp_t        e;
        cpb  = sel16 ? 16 : 1;
        bits = {stop, par, d, 1'b0};
        e.d  = d;
        e.pe = (par != (^d));
        e.fe = !stop;
        e.t0 = cyc + 1;
        if (sel16) q16.push_back(e);
        else       q1.push_back(e);
        for (int i = 0; i < 11; i++) begin
            for (int c = 0; c < cpb; c++) begin
                if (sel16) rx16 = bits[i];
                else       rx1  = bits[i];
                @(negedge clk);
            end
        end
        if (sel16) rx16 = 1'b1;
        else       rx1  = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && (q1.size() != 0 || q16.size() != 0); i++)
            @(negedge clk);
        check("drain pending", q1.size() + q16.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [7:0] d;
        logic       par;
        logic       stop;

        rx1     = 1'b1;
        rx16    = 1'b1;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset data1", dout1, 0);
        check("reset dv1", dv1, 0);
        check("reset pe1", pe1, 0);
        check("reset fe1", fe1, 0);
        check("reset busy1", busy1, 0);
        check("reset data16", dout16, 0);
        check("reset dv16", dv16, 0);
        check("reset busy16", busy16, 0);
        reset_n = 1'b1;

        repeat (50) begin
            @(negedge clk);
            check("idle dv1", dv1, 0);
            check("idle dv16", dv16, 0);
            check("idle busy1", busy1, 0);
            check("idle busy16", busy16, 0);
        end
        check("idle data1", dout1, 0);
        check("idle flags1", {pe1, fe1}, 0);

        send(0, 8'hA5, 1'b0, 1'b1);
        drain();

        send(0, 8'h01, 1'b0, 1'b1);
        drain();
        send(0, 8'h3C, 1'b0, 1'b0);
        drain();
        check("hold frame_err", fe1, 1);
        check("hold data", dout1, 8'h3C);

        send(0, 8'h00, 1'b0, 1'b1);
        send(0, 8'hFF, 1'b0, 1'b1);
        send(0, 8'h5A, 1'b0, 1'b1);
        drain();

        for (int k = 0; k < 30; k++) begin
            d    = 8'($urandom);
            par  = (^d) ^ ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 4) != 0);
            send(0, d, par, stop);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();

        rx16 = 1'b0;
        repeat (3) @(negedge clk);
        rx16 = 1'b1;
        check("glitch busy rise", busy16, 1);
        repeat (20) @(negedge clk);
        check("glitch busy fall", busy16, 0);
        check("glitch no pulse", q16.size(), 0);

        send(1, 8'hC3, 1'b0, 1'b1);
        drain();
        for (int k = 0; k < 4; k++) begin
            d    = 8'($urandom);
            par  = (^d) ^ ($urandom_range(0, 2) == 0);
            stop = ($urandom_range(0, 3) != 0);
            send(1, d, par, stop);
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end
        drain();

        rx1 = 1'b0;
        @(negedge clk);
        repeat (4) begin
            rx1 = 1'b1;
            @(negedge clk);
        end
        reset_n = 1'b0;
        rx1     = 1'b1;
        repeat (3) @(negedge clk);
        check("midreset busy", busy1, 0);
        check("midreset data", dout1, 0);
        check("midreset dv", dv1, 0);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("after abort busy", busy1, 0);
        send(0, 8'h12, 1'b0, 1'b1);
        drain();
        check("final data", dout1, 8'h12);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver, the far end of the team's UART transmitter.
- Frame format, one bit each: start(0), data[0..7] LSB first, parity, stop(1). Parity is even: parity bit = XOR of the data byte.
- Synchronizes the asynchronous `rx` line, finds the start bit, samples each bit at mid-bit, and presents the byte with a one-cycle valid pulse plus error flags.
- With `CLKS_PER_BIT=1` it receives the transmitter's one-bit-per-clock stream directly.

Parameters:
- CLKS_PER_BIT, 1, clock cycles per serial bit (≥1); mid-bit offset H = (CLKS_PER_BIT-1)/2, integer divide.
- SYNC_STAGES, 2, flops in the rx input synchronizer (≥2).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- rx  in  1  serial input, idle high.
- data_out  out  8  last received byte.
- data_valid  out  1  one-cycle pulse when a frame completes.
- parity_err  out  1  parity mismatch in the last frame.
- frame_err  out  1  stop bit sampled low in the last frame.
- busy  out  1  high while a frame is being received (state != IDLE).

Behaviour:
- Interface decision: one clock `clk`; reset `reset_n` is asynchronous and active-low.
- Reset values:
  - data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0.
  - FSM=IDLE; all counters 0.
  - Synchronizer flops reset to 1, so there is no false start after reset.
- rx_s is rx after SYNC_STAGES flops. All decisions use rx_s only.
- FSM states: IDLE, START, DATA, PARITY, STOP. clk_cnt counts cycles within a bit; bit_idx is 3 bits.
- IDLE:
  - On rx_s=0 this cycle is offset 0 of the start bit.
  - If H=0, go to DATA with clk_cnt=0.
  - Otherwise go to START with clk_cnt=1.
- START:
  - When clk_cnt=H, sample rx_s.
  - rx_s=0 → DATA, clk_cnt=0.
  - rx_s=1 → IDLE (glitch rejected; no flags or pulse).
- DATA:
  - When clk_cnt=CLKS_PER_BIT-1, sample rx_s into shift[bit_idx] (LSB first), reset clk_cnt, increment bit_idx.
  - After bit_idx=7 is sampled → PARITY.
- PARITY: same sample timing; store the parity bit → STOP.
- STOP: same sample timing. At that edge:
  - data_out ← shift.
  - parity_err ← (^shift) XOR parity bit.
  - frame_err ← ~rx_s.
  - data_valid=1 for exactly the following cycle.
  - FSM → IDLE.
- Flags and data_out hold until the next completed frame. data_valid pulses even when an error flag is set; the flags qualify that pulse.
- Back-to-back frames: a start bit may begin on the sample immediately after the stop sample (zero idle gap), so the `CLKS_PER_BIT=1` transmitter stream is received without loss.
- Stop bit sampled low: frame_err=1, FSM returns to IDLE. A continuing low line is treated as a new start (break is not specially handled).
- reset_n asserted mid-frame: immediate return to the reset state. The partial byte is discarded and no data_valid is produced.
- Latency (`CLKS_PER_BIT=1`, `SYNC_STAGES=2`):
  - rx start bit first present at edge T.
  - rx_s low at T+2, which is the start sample.
  - Stop sample at T+12; data_valid high in the cycle after edge T+12.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE/START/DATA/PARITY/STOP);
  - constants DATA_BITS=8, START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1;
  - even-parity function.
  - The transmitter reuses the same package.
- Sub-module uart_sync: SYNC_STAGES-deep synchronizer with reset value 1. It is reusable for any async input.

Test Plan:
- Reset then idle high for 50 cycles → data_valid never pulses; busy=0; all outputs 0.
- Single byte: CLKS_PER_BIT=1, send 0xA5 with parity 0 → one data_valid pulse, data_out=0xA5, parity_err=0, frame_err=0, pulse 13 cycles after the start bit is driven.
- Parity and framing errors: send 0x01 with parity 0 → data_out=0x01, parity_err=1. Then send 0x3C with stop bit 0 → frame_err=1, data_out=0x3C.
- Back-to-back with CLKS_PER_BIT=1: 0x00, 0xFF, 0x5A with zero idle gap → three pulses 11 cycles apart, correct bytes, no errors.
- Oversampling and glitch rejection with CLKS_PER_BIT=16:
  - 3-cycle low glitch → no pulse, busy returns to 0.
  - Then 0xC3 at 16 cycles/bit → data_out=0xC3, no errors.
- Reset mid-frame: assert reset_n=0 after 4 data bits of 0xFF, release, then send 0x12 → no pulse for the aborted frame; next pulse has data_out=0x12.
